fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the memory block.
- Drives memory's address/enable/rw/access_size port set and consumes data_out.
- Delivers one instruction at a time to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) with squash of in-flight responses.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues single-word reads at pc and hands each word to decode.
// Latency: request accepted in cycle N, data captured at the end of N+1, insn_valid from N+2 (3 cycles per insn best case).
// Backpressure: mem_busy holds the request and its address; insn_ready low holds insn/insn_pc and stalls further fetches.
module fetch_unit #(
   parameter int unsigned    ADDR_WIDTH = 32,
   parameter int unsigned    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h8002_0000
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic [1:0]            mem_access_size,
   output logic                  mem_rw,
   output logic                  mem_enable,
   input  logic                  mem_busy,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  insn_valid,
   input  logic                  insn_ready,
   output logic [DATA_WIDTH-1:0] insn,
   output logic [ADDR_WIDTH-1:0] insn_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  misalign_err,
   output logic [31:0]           fetch_count
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2,
      S_DROP  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_insn;
   logic [ADDR_WIDTH-1:0] r_insn_pc;
   logic                  r_insn_valid;
   logic                  r_misalign_err;
   logic [31:0]           r_fetch_count;

   logic                  w_accept;
   logic                  w_handshake;
   logic [ADDR_WIDTH-1:0] w_redirect_aligned;

   // The fetch never writes, so the write-side port set is tied off.
   assign mem_data_in     = '0;
   assign mem_access_size = 2'b00;
   assign mem_rw          = 1'b0;

   assign mem_enable  = (r_state == S_FETCH) && !reset;
   assign mem_address = r_pc;
   assign w_accept    = mem_enable && !mem_busy;
   assign w_handshake = r_insn_valid && insn_ready;
   assign w_redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

   assign insn_valid   = r_insn_valid;
   assign insn         = r_insn;
   assign insn_pc      = r_insn_pc;
   assign misalign_err = r_misalign_err;
   assign fetch_count  = r_fetch_count;

   // Next-state selection; a redirect overrides the normal flow, and a request
   // accepted in the same cycle must have its response dropped.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_FETCH: if (w_accept)    w_next_state = S_WAIT;
         S_WAIT:                   w_next_state = S_VALID;
         S_VALID: if (w_handshake) w_next_state = S_FETCH;
         S_DROP:                   w_next_state = S_FETCH;
         default:                  w_next_state = S_FETCH;
      endcase
      if (redirect_valid) begin
         unique case (r_state)
            S_FETCH: w_next_state = w_accept ? S_DROP : S_FETCH;
            S_DROP:  w_next_state = S_DROP;
            default: w_next_state = S_FETCH;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next_state;
   end

   // PC, delivered instruction and sticky status; redirect wins over capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc           <= START_ADDR;
         r_insn         <= '0;
         r_insn_pc      <= '0;
         r_insn_valid   <= 1'b0;
         r_misalign_err <= 1'b0;
      end else if (redirect_valid) begin
         r_pc         <= w_redirect_aligned;
         r_insn_valid <= 1'b0;
         if (redirect_pc[1:0] != 2'b00) r_misalign_err <= 1'b1;
      end else if (r_state == S_WAIT) begin
         r_insn       <= mem_data_out;
         r_insn_pc    <= r_pc;
         r_insn_valid <= 1'b1;
         r_pc         <= r_pc + ADDR_WIDTH'(4);
      end else if (w_handshake) begin
         r_insn_valid <= 1'b0;
      end
   end

   // Delivered-instruction counter; a handshake still counts when a redirect lands with it.
   always_ff @(posedge clock) begin
      if (reset)            r_fetch_count <= '0;
      else if (w_handshake) r_fetch_count <= r_fetch_count + 32'd1;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory responder.
// Inputs are driven 1 time unit after each rising edge; outputs checked in the same window.
// Memory data is only meaningful the cycle after acceptance, otherwise a poison word.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [1:0]  mem_access_size;
   logic        mem_rw;
   logic        mem_enable;
   logic        mem_busy;
   logic [31:0] mem_data_out;
   logic        insn_valid;
   logic        insn_ready;
   logic [31:0] insn;
   logic [31:0] insn_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        misalign_err;
   logic [31:0] fetch_count;

   int n_vec = 0;
   int n_err = 0;

   fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .mem_address     (mem_address),
      .mem_data_in     (mem_data_in),
      .mem_access_size (mem_access_size),
      .mem_rw          (mem_rw),
      .mem_enable      (mem_enable),
      .mem_busy        (mem_busy),
      .mem_data_out    (mem_data_out),
      .insn_valid      (insn_valid),
      .insn_ready      (insn_ready),
      .insn            (insn),
      .insn_pc         (insn_pc),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .misalign_err    (misalign_err),
      .fetch_count     (fetch_count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   // Memory responder: data for an accepted request appears the following cycle.
   always @(posedge clock) begin
      if (mem_enable && !mem_busy) mem_data_out <= mem_word(mem_address);
      else                         mem_data_out <= 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; insn_ready = 1'b1; mem_busy = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      tick(); tick();

      // Reset state and constant outputs.
      chk("rst_en",     {31'd0, mem_enable},   32'd0);
      chk("rst_valid",  {31'd0, insn_valid},   32'd0);
      chk("rst_count",  fetch_count,           32'd0);
      chk("rst_insn",   insn,                  32'd0);
      chk("rst_ipc",    insn_pc,               32'd0);
      chk("rst_mis",    {31'd0, misalign_err}, 32'd0);
      chk("rst_addr",   mem_address,           32'h8002_0000);
      chk("rst_const",  {mem_data_in[29:0], mem_access_size}, 32'd0);
      chk("rst_rw",     {31'd0, mem_rw},       32'd0);

      // Streaming with insn_ready high: one instruction every 3 cycles.
      reset = 1'b0; #1;
      chk("c0_en",   {31'd0, mem_enable}, 32'd1);
      chk("c0_addr", mem_address,         32'h8002_0000);
      tick();
      chk("c1_en",    {31'd0, mem_enable}, 32'd0);
      chk("c1_valid", {31'd0, insn_valid}, 32'd0);
      tick();
      chk("c2_valid", {31'd0, insn_valid}, 32'd1);
      chk("c2_insn",  insn,                mem_word(32'h8002_0000));
      chk("c2_ipc",   insn_pc,             32'h8002_0000);
      tick();
      chk("c3_addr",  mem_address,         32'h8002_0004);
      chk("c3_count", fetch_count,         32'd1);
      tick(); tick();
      chk("c5_ipc",   insn_pc,             32'h8002_0004);
      tick();
      chk("c6_addr",  mem_address,         32'h8002_0008);
      tick(); tick(); tick();
      chk("c9_count", fetch_count,         32'd3);
      chk("c9_addr",  mem_address,         32'h8002_000C);

      // Memory busy for 4 cycles holds the request.
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("busy_en",   {31'd0, mem_enable}, 32'd1);
         chk("busy_addr", mem_address,         32'h8002_000C);
      end
      mem_busy = 1'b0;
      tick();
      chk("busy_wait_en", {31'd0, mem_enable}, 32'd0);
      insn_ready = 1'b0;
      tick();

      // Decode stall for 5 cycles holds the instruction.
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'd0, insn_valid}, 32'd1);
         chk("stall_insn",  insn,                mem_word(32'h8002_000C));
         chk("stall_ipc",   insn_pc,             32'h8002_000C);
         chk("stall_en",    {31'd0, mem_enable}, 32'd0);
         chk("stall_count", fetch_count,         32'd3);
         tick();
      end
      insn_ready = 1'b1;
      tick();
      chk("unstall_count", fetch_count,         32'd4);
      chk("unstall_addr",  mem_address,         32'h8002_0010);
      chk("unstall_en",    {31'd0, mem_enable}, 32'd1);

      // Redirect during WAIT discards the returning word.
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h8002_0100;
      tick();
      redirect_valid = 1'b0;
      chk("rw_valid", {31'd0, insn_valid}, 32'd0);
      chk("rw_addr",  mem_address,         32'h8002_0100);
      chk("rw_en",    {31'd0, mem_enable}, 32'd1);
      tick(); tick();
      chk("rw_ipc",   insn_pc,             32'h8002_0100);
      chk("rw_insn",  insn,                mem_word(32'h8002_0100));
      tick();
      chk("rw_count", fetch_count,         32'd5);
      chk("rw_next",  mem_address,         32'h8002_0104);

      // Misaligned redirect in an accepted FETCH cycle goes through DROP.
      redirect_valid = 1'b1; redirect_pc = 32'h8002_0042;
      tick();
      redirect_valid = 1'b0;
      chk("drop_en",  {31'd0, mem_enable},   32'd0);
      chk("drop_mis", {31'd0, misalign_err}, 32'd1);
      tick();
      chk("drop_addr", mem_address,          32'h8002_0040);
      chk("drop_en2",  {31'd0, mem_enable},  32'd1);
      tick(); tick();
      chk("drop_ipc",  insn_pc,              32'h8002_0040);
      chk("drop_insn", insn,                 mem_word(32'h8002_0040));

      // Redirect coinciding with a handshake: count still advances.
      redirect_valid = 1'b1; redirect_pc = 32'h8002_0200;
      tick();
      redirect_valid = 1'b0;
      chk("rh_count", fetch_count,           32'd6);
      chk("rh_addr",  mem_address,           32'h8002_0200);
      chk("rh_valid", {31'd0, insn_valid},   32'd0);
      chk("rh_mis",   {31'd0, misalign_err}, 32'd1);

      // Redirect in a busy FETCH, then pc wrap past the top of memory.
      mem_busy = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      mem_busy = 1'b0; redirect_valid = 1'b0;
      chk("wrap_addr", mem_address,         32'hFFFF_FFFC);
      chk("wrap_en",   {31'd0, mem_enable}, 32'd1);
      tick(); tick();
      chk("wrap_ipc",  insn_pc,             32'hFFFF_FFFC);
      tick();
      chk("wrap_next", mem_address,         32'h0000_0000);
      chk("wrap_count", fetch_count,        32'd7);

      // Reset during WAIT discards everything and restarts at the base.
      tick();
      reset = 1'b1;
      tick();
      chk("rs_en",    {31'd0, mem_enable},   32'd0);
      chk("rs_valid", {31'd0, insn_valid},   32'd0);
      chk("rs_count", fetch_count,           32'd0);
      chk("rs_mis",   {31'd0, misalign_err}, 32'd0);
      reset = 1'b0; #1;
      chk("rs_addr",  mem_address,           32'h8002_0000);
      chk("rs_en2",   {31'd0, mem_enable},   32'd1);
      tick(); tick();
      chk("rs_ipc",   insn_pc,               32'h8002_0000);
      chk("rs_insn",  insn,                  mem_word(32'h8002_0000));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
